// File: rtl/wb_pipe_reg_pkg.sv
// Shared core definitions used by the MEM/WB pipeline register and its helpers.
// Holds the bus types, the stall and write-enable encodings, and the per-cycle action type.
package wb_pipe_reg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_t;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam reg_t      ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  // Exactly one of these is taken per non-reset cycle.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } action_e;

endpackage

// File: rtl/wb_pipe_reg_if.sv
// Memory-stage bundle in, writeback bundle out.
// Lane i of a packed vector occupies [i*AW +: AW] / [i*DW +: DW]; a lane is live only when its valid bit is set (no ready: the stall vector throttles).
interface wb_pipe_reg_if #(
  parameter int LANES = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
);

  logic [LANES-1:0]    mem_valid;
  logic [LANES*AW-1:0] mem_wd;
  logic [LANES-1:0]    mem_wreg;
  logic [LANES*DW-1:0] mem_wdata;
  logic [DW-1:0]       mem_hi;
  logic [DW-1:0]       mem_lo;
  logic                mem_whilo;

  logic [LANES-1:0]    wb_valid;
  logic [LANES*AW-1:0] wb_wd;
  logic [LANES-1:0]    wb_wreg;
  logic [LANES*DW-1:0] wb_wdata;
  logic [DW-1:0]       wb_hi;
  logic [DW-1:0]       wb_lo;
  logic                wb_whilo;

  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo
  );

  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo
  );

endinterface

// File: rtl/wb_pipe_reg_lane_popcount.sv
// Combinational count of set lane-valid bits, used to advance the retired-lane counter.
module lane_popcount #(
  parameter int LANES = 2,
  parameter int OUT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] valid_i,
  output logic [OUT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      count_o = count_o + OUT_W'(valid_i[i]);
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: per-lane valid, flush, stall-driven hold/bubble,
// intra-bundle WAW squashing and wrapping retired/bubble counters.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  wb_pipe_reg_if.slave       bus,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int PCW = $clog2(LANES + 1);

  action_e action;

  logic [LANES-1:0]    valid_q, valid_d;
  logic [LANES*AW-1:0] wd_q, wd_d;
  logic [LANES-1:0]    wreg_q, wreg_d;
  logic [LANES*DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0]       hi_q, hi_d;
  logic [DW-1:0]       lo_q, lo_d;
  logic                whilo_q, whilo_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [CNT_W-1:0]    bub_q, bub_d;

  logic [LANES-1:0]    wreg_load;
  logic [PCW-1:0]      valid_pop;
  logic                unused_stall;

  assign unused_stall = ^stall;

  // Flush outranks the stall vector; a stalled stage whose successor moves
  // must emit a bubble, otherwise the register freezes.
  always_comb begin
    action = ACT_HOLD;
    if (flush) begin
      action = ACT_BUBBLE;
    end else if (stall[STAGE] == NO_STOP) begin
      action = ACT_LOAD;
    end else if (stall[STAGE+1] == NO_STOP) begin
      action = ACT_BUBBLE;
    end
  end

  // A lane's write is dropped if a younger lane in the same bundle writes the
  // same register; writes to r0 are never performed.
  for (genvar i = 0; i < LANES; i++) begin : g_waw
    logic waw_hit;

    always_comb begin
      waw_hit = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (bus.mem_valid[j] && bus.mem_wreg[j] &&
            (bus.mem_wd[j*AW +: AW] == bus.mem_wd[i*AW +: AW])) begin
          waw_hit = 1'b1;
        end
      end
    end

    assign wreg_load[i] = bus.mem_wreg[i] & bus.mem_valid[i] &
                          (bus.mem_wd[i*AW +: AW] != AW'(NOP_REG_ADDR)) & ~waw_hit;
  end

  lane_popcount #(
    .LANES (LANES),
    .OUT_W (PCW)
  ) u_lane_popcount (
    .valid_i (bus.mem_valid),
    .count_o (valid_pop)
  );

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    ret_d   = ret_q;
    bub_d   = bub_q;
    case (action)
      ACT_LOAD: begin
        valid_d = bus.mem_valid;
        wd_d    = bus.mem_wd;
        wreg_d  = wreg_load;
        wdata_d = bus.mem_wdata;
        hi_d    = bus.mem_hi;
        lo_d    = bus.mem_lo;
        whilo_d = bus.mem_whilo & (|bus.mem_valid);
        ret_d   = ret_q + CNT_W'(valid_pop);
      end
      ACT_BUBBLE: begin
        valid_d = '0;
        wd_d    = '0;
        wreg_d  = {LANES{WRITE_DISABLE}};
        wdata_d = '0;
        hi_d    = DW'(ZERO_WORD);
        lo_d    = DW'(ZERO_WORD);
        whilo_d = WRITE_DISABLE;
        bub_d   = bub_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wd_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      ret_q   <= '0;
      bub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_wd    = wd_q;
  assign bus.wb_wreg  = wreg_q;
  assign bus.wb_wdata = wdata_q;
  assign bus.wb_hi    = hi_q;
  assign bus.wb_lo    = lo_q;
  assign bus.wb_whilo = whilo_q;
  assign retired_cnt  = ret_q;
  assign bubble_cnt   = bub_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: two lanes, stall bit 4, 4-bit counters so wrap is reachable.
module tb_wb_pipe_reg;

  localparam int LANES   = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;
  localparam int CNT_W   = 4;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [CNT_W-1:0]   retired_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [CNT_W-1:0] exp_ret;
  logic [CNT_W-1:0] exp_bub;

  wb_pipe_reg_if #(.LANES(LANES), .AW(AW), .DW(DW)) bus ();

  wb_pipe_reg #(
    .LANES   (LANES),
    .AW      (AW),
    .DW      (DW),
    .STALL_W (STALL_W),
    .STAGE   (STAGE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .bus         (bus),
    .retired_cnt (retired_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stall controller never releases this stage while the next one holds.
  always @(negedge clk) begin
    if (!rst) begin
      n_assert++;
      assert (!(stall[STAGE] == 1'b0 && stall[STAGE+1] == 1'b1)) else begin
        n_fail++;
        $error("FAIL stall_combo: observed stall=%b required no load-under-hold", stall);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [4:0] wd1, input logic [4:0] wd0,
                       input logic [1:0] wreg, input logic [31:0] d1, input logic [31:0] d0);
    bus.mem_valid = valid;
    bus.mem_wd    = {wd1, wd0};
    bus.mem_wreg  = wreg;
    bus.mem_wdata = {d1, d0};
  endtask

  task automatic drive_hilo(input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    bus.mem_whilo = whilo;
    bus.mem_hi    = hi;
    bus.mem_lo    = lo;
  endtask

  task automatic chk_bundle_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.wb_valid), 64'd0);
    chk({tag, "_wd"},    64'(bus.wb_wd),    64'd0);
    chk({tag, "_wreg"},  64'(bus.wb_wreg),  64'd0);
    chk({tag, "_wdata"}, 64'(bus.wb_wdata), 64'd0);
    chk({tag, "_hi"},    64'(bus.wb_hi),    64'd0);
    chk({tag, "_lo"},    64'(bus.wb_lo),    64'd0);
    chk({tag, "_whilo"}, 64'(bus.wb_whilo), 64'd0);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_retired"}, 64'(retired_cnt), 64'(exp_ret));
    chk({tag, "_bubble"},  64'(bubble_cnt),  64'(exp_bub));
  endtask

  initial begin
    // Reset with random inputs
    rst   = 1'b1;
    flush = 1'($urandom_range(0, 1));
    stall = 6'($urandom_range(0, 63));
    drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          2'($urandom_range(0, 3)), $urandom, $urandom);
    drive_hilo(1'($urandom_range(0, 1)), $urandom, $urandom);
    step();
    step();
    exp_ret = '0;
    exp_bub = '0;
    chk_bundle_zero("reset");
    chk_counters("reset");

    // First load after reset: both lanes valid
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    drive(2'b11, 5'd7, 5'd3, 2'b11, 32'h55, 32'h1234);
    drive_hilo(1'b0, 32'h0, 32'h0);
    step();
    exp_ret = 4'd2;
    chk("load_wd0",    64'(bus.wb_wd[4:0]),      64'd3);
    chk("load_wd1",    64'(bus.wb_wd[9:5]),      64'd7);
    chk("load_wreg",   64'(bus.wb_wreg),         64'b11);
    chk("load_wdata0", 64'(bus.wb_wdata[31:0]),  64'h1234);
    chk("load_wdata1", 64'(bus.wb_wdata[63:32]), 64'h55);
    chk("load_valid",  64'(bus.wb_valid),        64'b11);
    chk_counters("load");

    // Stage stalled, successor free: bubble
    stall = 6'b011111;
    step();
    exp_bub = 4'd1;
    chk_bundle_zero("bubble");
    chk_counters("bubble");

    // Load a single-lane bundle, then hold it for three cycles with changing inputs
    stall = 6'b000000;
    drive(2'b01, 5'd0, 5'd3, 2'b01, 32'h0, 32'h1234);
    step();
    exp_ret = 4'd3;
    stall = 6'b111111;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 5'd9, 5'd8, 2'b11, $urandom, $urandom);
      step();
      chk("hold_valid",  64'(bus.wb_valid),       64'b01);
      chk("hold_wd0",    64'(bus.wb_wd[4:0]),     64'd3);
      chk("hold_wreg",   64'(bus.wb_wreg),        64'b01);
      chk("hold_wdata0", 64'(bus.wb_wdata[31:0]), 64'h1234);
      chk_counters("hold");
    end

    // Both lanes write r5: youngest lane wins
    stall = 6'b000000;
    drive(2'b11, 5'd5, 5'd5, 2'b11, 32'hB, 32'hA);
    step();
    exp_ret = 4'd5;
    chk("waw_wreg",   64'(bus.wb_wreg),         64'b10);
    chk("waw_wdata1", 64'(bus.wb_wdata[63:32]), 64'hB);
    chk("waw_wdata0", 64'(bus.wb_wdata[31:0]),  64'hA);
    chk("waw_valid",  64'(bus.wb_valid),        64'b11);
    chk_counters("waw");

    // Lane0 targets r0: valid but no write
    drive(2'b11, 5'd6, 5'd0, 2'b11, 32'h66, 32'h77);
    step();
    exp_ret = 4'd7;
    chk("r0_wreg",  64'(bus.wb_wreg),  64'b10);
    chk("r0_valid", 64'(bus.wb_valid), 64'b11);
    chk_counters("r0");

    // Invalid younger lane with the same target does not squash
    drive(2'b01, 5'd5, 5'd5, 2'b11, 32'h1, 32'h2);
    step();
    exp_ret = 4'd8;
    chk("waw_inv_wreg",  64'(bus.wb_wreg),  64'b01);
    chk("waw_inv_valid", 64'(bus.wb_valid), 64'b01);
    chk_counters("waw_inv");

    // Younger lane without write enable does not squash
    drive(2'b11, 5'd5, 5'd5, 2'b01, 32'h1, 32'h2);
    step();
    exp_ret = 4'd10;
    chk("waw_nowr_wreg", 64'(bus.wb_wreg), 64'b01);
    chk_counters("waw_nowr");

    // Flush beats a free-running load
    flush = 1'b1;
    drive(2'b11, 5'd2, 5'd1, 2'b11, 32'h3, 32'h4);
    step();
    exp_bub = 4'd2;
    chk_bundle_zero("flush_run");
    chk_counters("flush_run");

    // Flush during a hold discards the held bundle
    flush = 1'b0;
    step();
    exp_ret = 4'd12;
    chk("pre_flush_hold_valid", 64'(bus.wb_valid), 64'b11);
    flush = 1'b1;
    stall = 6'b111111;
    step();
    exp_bub = 4'd3;
    chk_bundle_zero("flush_hold");
    chk_counters("flush_hold");

    // HI/LO write with one valid lane
    flush = 1'b0;
    stall = 6'b000000;
    drive(2'b01, 5'd0, 5'd4, 2'b00, 32'h0, 32'h0);
    drive_hilo(1'b1, 32'hDEAD, 32'hBEEF);
    step();
    exp_ret = 4'd13;
    chk("hilo_whilo", 64'(bus.wb_whilo), 64'd1);
    chk("hilo_hi",    64'(bus.wb_hi),    64'hDEAD);
    chk("hilo_lo",    64'(bus.wb_lo),    64'hBEEF);
    chk_counters("hilo");

    // Same HI/LO inputs with no valid lane: enable dropped, values still captured
    bus.mem_valid = 2'b00;
    step();
    chk("hilo_inv_whilo", 64'(bus.wb_whilo), 64'd0);
    chk("hilo_inv_hi",    64'(bus.wb_hi),    64'hDEAD);
    chk_counters("hilo_inv");

    // Reset while held discards the bundle
    stall = 6'b111111;
    rst = 1'b1;
    step();
    exp_ret = '0;
    exp_bub = '0;
    chk_bundle_zero("reset_hold");
    chk_counters("reset_hold");

    // Retired counter wraps modulo 16
    rst = 1'b0;
    stall = 6'b000000;
    drive(2'b11, 5'd2, 5'd1, 2'b11, 32'h10, 32'h20);
    drive_hilo(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) step();
    exp_ret = 4'd14;
    chk_counters("wrap_7");
    step();
    exp_ret = 4'd0;
    chk_counters("wrap_8");
    step();
    exp_ret = 4'd2;
    chk_counters("wrap_9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM/WB pipeline register for the multi-issue core: captures a bundle of `LANES` memory-stage results and presents them to writeback one cycle later. Adds per-lane valid bits, an explicit flush, configurable stall-vector position, intra-bundle write-after-write squashing and two wrapping performance counters (retired lanes, inserted bubbles). It sits between the memory stage and the register file / HI-LO unit and is driven by the central stall controller.

## Interface

**Parameters**
- `LANES`, 2: issue width; legal range 1..4.
- `AW`, 5: register address width.
- `DW`, 32: data width of register, HI and LO values.
- `STALL_W`, 6: stall vector width.
- `STAGE`, 4: index of this register's stall bit; `STAGE+1 < STALL_W`.
- `CNT_W`, 32: width of both performance counters.

**Ports** (lane `i` occupies bits `[i*AW +: AW]` / `[i*DW +: DW]` of packed vectors)
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, `STALL_W`: stall vector from the stall controller; 1 = Stop.
- `flush`, in, 1: exception flush; turns this cycle's capture into a bubble.
- `mem_valid`, in, `LANES`: lane carries a real instruction.
- `mem_wd`, in, `LANES*AW`: destination register per lane.
- `mem_wreg`, in, `LANES`: register write enable per lane.
- `mem_wdata`, in, `LANES*DW`: write data per lane.
- `mem_hi`, `mem_lo`, in, `DW` each: bundle HI/LO result.
- `mem_whilo`, in, 1: bundle HI/LO write enable.
- `wb_valid`, out, `LANES`: registered valid bits.
- `wb_wd`, out, `LANES*AW`: registered destinations.
- `wb_wreg`, out, `LANES`: registered write enables, after squashing.
- `wb_wdata`, out, `LANES*DW`: registered data.
- `wb_hi`, `wb_lo`, out, `DW`: registered HI/LO values.
- `wb_whilo`, out, 1: registered HI/LO write enable.
- `retired_cnt`, out, `CNT_W`: count of valid lanes loaded.
- `bubble_cnt`, out, `CNT_W`: count of bubble cycles inserted.

## Operation

Each cycle takes exactly one action, chosen in this priority order:
1. **Reset** (`rst`=1): all outputs, both counters included, go to 0.
2. **Flush** (`flush`=1): bubble, regardless of `stall`.
3. **Bubble** (`stall[STAGE]`=1 and `stall[STAGE+1]`=0): bubble.
4. **Load** (`stall[STAGE]`=0): capture the inputs.
5. **Hold** (`stall[STAGE]`=1 and `stall[STAGE+1]`=1): all outputs and counters keep their values.

**Bubble**
- `wb_valid`, `wb_wd`, `wb_wreg`, `wb_wdata`, `wb_hi`, `wb_lo` and `wb_whilo` all go to 0.
- `bubble_cnt` increments by 1.

**Load**
- `wb_wd`, `wb_wdata`, `wb_hi` and `wb_lo` take the inputs unchanged.
- `wb_valid[i]` takes `mem_valid[i]`.
- `wb_wreg[i]` takes `mem_wreg[i] & mem_valid[i] & (mem_wd[i] != 0) & ~waw[i]`.
  - `waw[i]` = 1 if any higher lane `j > i` has `mem_valid[j] & mem_wreg[j] & mem_wd[j] == mem_wd[i]`. The youngest lane wins.
- `wb_whilo` takes `mem_whilo & |mem_valid`.
- `retired_cnt` increases by the popcount of `mem_valid`.

**Counters**
- Both counters wrap modulo 2^`CNT_W`; there is no saturation.
- A bubble and a load can never happen in the same cycle, so the counters never update together.

## Timing

- Latency is 1 cycle: inputs present before edge N appear on the `wb_*` outputs after edge N.
- No combinational path from any input to any output.
- Reset takes effect at the first edge with `rst`=1. If it arrives mid-stall, the held bundle is discarded.
- `flush` during a hold (stall[STAGE+1]=1) still produces a bubble. The downstream stage must tolerate losing a held bundle on exception.
- If `stall[STAGE]` drops while `stall[STAGE+1]` stays high, the register loads (decision 4 precedes decision 5). The stall controller guarantees this combination never occurs; the bench checks for it with an assertion and does not drive it.

## Structure

- The shared core defines package holds `RegAddrBus`/`RegBus` equivalents, the Stop/NoStop and WriteEnable/WriteDisable constants, and the zero-word / NOP-address constants.
- One sub-module, `lane_popcount`: combinational, `LANES` in → `$clog2(LANES+1)` bits out; it feeds `retired_cnt`.
- The WAW squash logic is a generate loop inside `wb_pipe_reg`.

## Test plan

- **Reset.** Drive `rst`=1 for 2 cycles with random inputs → every output and both counters read 0. Then release and load one bundle: with `LANES`=2, `mem_valid`=2'b11 → `retired_cnt`=2.
- **Load / bubble / hold.** Use `STAGE`=4.
  - `stall`=6'b000000, lane0 writes r3=0x1234 → next cycle `wb_wd[0]`=3, `wb_wreg[0]`=1, `wb_wdata[0]`=0x1234.
  - `stall`=6'b011111 → bubble: all zero, `bubble_cnt`+1.
  - `stall`=6'b111111 → outputs frozen and counters unchanged for 3 cycles.
- **WAW squash and r0.**
  - Both lanes write r5 (0xA, 0xB) → `wb_wreg`=2'b10, `wb_wdata[1]`=0xB.
  - Lane0 writes r0 → `wb_wreg[0]`=0 while `wb_valid[0]`=1.
- **Flush priority.** `flush`=1 with `stall`=6'b000000 → bubble, `retired_cnt` unchanged. `flush`=1 with `stall`=6'b111111 → bubble.
- **HI/LO.**
  - `mem_whilo`=1, hi=0xDEAD, lo=0xBEEF, `mem_valid`=2'b01 → `wb_whilo`=1 with those values.
  - Same inputs with `mem_valid`=0 → `wb_whilo`=0.
- **Counter wrap.** Use `CNT_W`=4. Load 8 bundles with `mem_valid`=2'b11 → `retired_cnt` = 16 mod 16 = 0; one more bundle → 2.
